// File: rtl/drp_reconf_seq_if.sv
// rtl/drp_reconf_seq_if.sv - DRP bus between the reconfiguration sequencer and the PLL register file
interface drp_reconf_seq_if;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;

    modport master (output daddr, den, dwe, di, input dout, drdy);
    modport slave  (input daddr, den, dwe, di, output dout, drdy);
endinterface

// File: rtl/drp_reconf_seq.sv
// rtl/drp_reconf_seq.sv - DRP read-modify-write table walker that then pulses PLL reset and waits for lock
module drp_reconf_seq #(
    parameter int NUM_ENTRIES  = 23,
    parameter int IDX_W        = 5,
    parameter int DRDY_TIMEOUT = 255,
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 dclk,
    input  logic                 rst,
    input  logic                 sen,
    output logic                 busy,
    output logic                 srdy,
    output logic                 serr,
    output logic [IDX_W-1:0]     entry_idx,
    input  logic [6:0]           entry_addr,
    input  logic [15:0]          entry_mask,
    input  logic [15:0]          entry_data,
    input  logic                 locked,
    output logic                 pll_rst,
    drp_reconf_seq_if.master     drp
);
    localparam int MAX_TO  = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_TO > RST_CYCLES) ? MAX_TO : RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, WR_WAIT, NEXT, PRST, LOCK_WAIT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [6:0]        daddr_q;
    logic [15:0]       di_q;
    logic              den_q;
    logic              dwe_q;
    logic [15:0]       merged;
    logic              ack;

    assign merged = (drp.dout & entry_mask) | (entry_data & ~entry_mask);
    // DRDY is still high from the previous idle period in the first wait cycle, so ignore it there
    assign ack    = (cnt != '0) && drp.drdy;

    // The table index only settles on entering RD, so the read address comes straight from the table
    assign drp.daddr = (state == RD) ? entry_addr : daddr_q;
    assign drp.den   = den_q;
    assign drp.dwe   = dwe_q;
    assign drp.di    = di_q;

    always_ff @(posedge dclk) begin
        if (rst) begin
            state     <= IDLE;
            entry_idx <= '0;
            cnt       <= '0;
            daddr_q   <= '0;
            di_q      <= '0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            busy      <= 1'b0;
            srdy      <= 1'b0;
            serr      <= 1'b0;
            pll_rst   <= 1'b0;
        end else begin
            den_q <= 1'b0;
            dwe_q <= 1'b0;
            srdy  <= 1'b0;
            serr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sen) begin
                        state     <= RD;
                        entry_idx <= '0;
                        busy      <= 1'b1;
                        den_q     <= 1'b1;
                    end
                end
                RD: begin
                    daddr_q <= entry_addr;
                    cnt     <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ack) begin
                        di_q  <= merged;
                        den_q <= 1'b1;
                        dwe_q <= 1'b1;
                        state <= WR;
                    end else if (cnt == DRDY_LAST) begin
                        serr  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR: begin
                    cnt   <= '0;
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (ack) begin
                        state <= NEXT;
                    end else if (cnt == DRDY_LAST) begin
                        serr  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    if (entry_idx == LAST_IDX) begin
                        pll_rst <= 1'b1;
                        cnt     <= '0;
                        state   <= PRST;
                    end else begin
                        entry_idx <= entry_idx + IDX_W'(1);
                        den_q     <= 1'b1;
                        state     <= RD;
                    end
                end
                PRST: begin
                    if (cnt == RST_LAST) begin
                        pll_rst <= 1'b0;
                        cnt     <= '0;
                        state   <= LOCK_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOCK_WAIT: begin
                    if (locked) begin
                        srdy  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == LOCK_LAST) begin
                        serr  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
